// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared address, requester index and read-tag types for the ByteRam port arbiter
package ram_port_arbiter_pkg;
  localparam int RAM_ADDR_W = 8;
  typedef logic [RAM_ADDR_W-1:0] RamAddr_t;
  typedef logic [1:0] ReqIdx_t;
  typedef struct packed {
    logic    valid;
    ReqIdx_t idx;
  } RdTag_t;
endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// ram_port_arbiter_rr_pick: combinational round-robin picker, first valid requester at or after ptr wins
module ram_port_arbiter_rr_pick
  import ram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  ReqIdx_t            ptr,
  output logic [NUM_REQ-1:0] grant,
  output ReqIdx_t            idx,
  output logic               any
);
  int best;
  // keep the valid requester with the smallest circular distance from ptr
  always_comb begin
    best = NUM_REQ;
    idx  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (valid[j] && ((j - int'(ptr) + NUM_REQ) % NUM_REQ) < best) begin
        best = (j - int'(ptr) + NUM_REQ) % NUM_REQ;
        idx  = ReqIdx_t'(j);
      end
    end
    any   = |valid;
    grant = any ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of the ByteRam read port with tagged response routing and write pass-through
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_REQ-1:0]        ReqValid,
  input  RamAddr_t [NUM_REQ-1:0]    ReqAddr,
  output logic [NUM_REQ-1:0]        ReqReady,
  output logic [NUM_REQ-1:0]        RspValid,
  output logic [7:0]                RspData,
  input  logic                      WrValid,
  input  RamAddr_t                  WrAddr,
  input  logic [7:0]                WrData,
  output logic                      WrReady,
  output RamAddr_t                  ReadAddr,
  output logic                      ReadEnable,
  input  logic [7:0]                ReadData,
  output RamAddr_t                  WriteAddr,
  output logic                      WriteEnable,
  output logic [7:0]                WriteData,
  output logic                      Busy
);
  logic [NUM_REQ-1:0] grant;
  ReqIdx_t            ptr, idx;
  logic               any, hazard, xfer, in_flight;
  RamAddr_t           sel_addr;
  RdTag_t             pipe [RD_LATENCY];

  ram_port_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid(ReqValid),
    .ptr  (ptr),
    .grant(grant),
    .idx  (idx),
    .any  (any)
  );

  // address of the requester the picker selected
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) sel_addr = grant[i] ? ReqAddr[i] : sel_addr;
  end

  // a same-cycle write to the winner's address defers the winner so it reads the new data
  assign hazard     = WrValid && sel_addr == WrAddr;
  assign xfer       = any && !hazard && !Rst;
  assign ReqReady   = xfer ? grant : '0;
  assign ReadEnable = xfer;
  assign ReadAddr   = xfer ? sel_addr : '0;

  assign WriteEnable = WrValid;
  assign WriteAddr   = WrAddr;
  assign WriteData   = WrData;
  assign WrReady     = !Rst;

  // advance priority past the last granted requester, wrapping at NUM_REQ
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) ptr <= '0;
    else if (xfer) ptr <= (idx == ReqIdx_t'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  end

  // tag pipeline aligned with the RAM read latency so data returns to its issuer
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int k = 0; k < RD_LATENCY; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= RdTag_t'{valid: xfer, idx: idx};
      for (int k = 1; k < RD_LATENCY; k++) pipe[k] <= pipe[k-1];
    end
  end

  // any tag still travelling towards the response port
  always_comb begin
    in_flight = 1'b0;
    for (int k = 0; k < RD_LATENCY; k++) in_flight = in_flight | pipe[k].valid;
  end

  assign RspValid = pipe[RD_LATENCY-1].valid ? NUM_REQ'(1) << pipe[RD_LATENCY-1].idx : '0;
  assign RspData  = ReadData;
  assign Busy     = |ReqValid || in_flight;
endmodule
